// File: rtl/adc_sample_averager.sv
// -----------------------------------------------------------------------------
// adc_sample_averager
//
// Purpose:
//   Issues periodic start pulses to a 16-bit SPI ADC master and captures each
//   word when the master's chip select deasserts. It averages 2**AVG_LOG2
//   consecutive samples and sends the result out on a valid/ready stream.
//   A transfer that never completes is aborted by a timeout. Samples or
//   averages lost to back-pressure or late transfers are flagged.
//
// Optional feature:
//   ADC_AVG_MINMAX_EN : when defined, adds o_avg_min / o_avg_max. These hold
//                       the smallest and largest sample of the window and are
//                       updated together with o_avg_data.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous reset, active-high
//   i_enable       1 = sampling runs; 0 = finish the current transfer, then idle
//   o_spi_start    one-cycle start pulse to the SPI master
//   i_spi_cs_n     SPI master chip select; a 0->1 edge marks completion
//   i_spi_data     SPI master parallel data, valid in the cycle cs_n rises
//   o_avg_data     averaged sample (unsigned, truncated)
//   o_avg_valid    o_avg_data valid; held until accepted
//   i_avg_ready    downstream accept
//   o_err_timeout  sticky: a transfer timed out
//   o_err_overrun  sticky: an average was overwritten or a trigger was missed
//   i_err_clr      synchronous clear of both sticky flags (a same-cycle set wins)
//   o_avg_min      window minimum   (ADC_AVG_MINMAX_EN only)
//   o_avg_max      window maximum   (ADC_AVG_MINMAX_EN only)
//   o_dbg_state    current FSM state (0 IDLE, 1 START, 2 WAIT, 3 ACCUM)
//
// Output stream handshake:
//   A word transfers on every clock edge where o_avg_valid & i_avg_ready are
//   both 1. Once o_avg_valid is raised, it and o_avg_data stay stable until
//   that transfer happens. The one exception is a new average that completes
//   before the transfer: it replaces the data and sets o_err_overrun. After a
//   transfer, o_avg_valid drops in the next cycle. If a new average loads in
//   the same cycle as the transfer, o_avg_valid stays 1 with the new data and
//   no error is flagged.
// -----------------------------------------------------------------------------
module adc_sample_averager #(
  parameter int SAMPLE_DIV  = 5000,
  parameter int AVG_LOG2    = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic        o_spi_start,
  input  logic        i_spi_cs_n,
  input  logic [15:0] i_spi_data,
  output logic [15:0] o_avg_data,
  output logic        o_avg_valid,
  input  logic        i_avg_ready,
  output logic        o_err_timeout,
  output logic        o_err_overrun,
  input  logic        i_err_clr,
`ifdef ADC_AVG_MINMAX_EN
  output logic [15:0] o_avg_min,
  output logic [15:0] o_avg_max,
`endif
  output logic [1:0]  o_dbg_state
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int ACC_W  = 16 + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_ACCUM = 2'd3
  } state_t;

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_sample;
  logic                r_cs_n_q;

  logic                w_tick;
  logic                w_cs_rise;
  logic                w_win_done;
  logic                w_load;
  logic                w_to_set;
  logic                w_ovr_set;
  logic [ACC_W-1:0]    w_acc_total;
  logic [ACC_W-1:0]    w_avg_shift;

  assign o_dbg_state = r_state;

  assign w_tick      = i_enable && (r_tick_cnt == TICK_LAST);
  assign w_cs_rise   = !r_cs_n_q && i_spi_cs_n;
  assign w_win_done  = (r_cnt == CNT_LAST);
  assign w_load      = (r_state == S_ACCUM) && w_win_done;
  // The accumulator is 16+AVG_LOG2 bits wide, so it cannot overflow.
  assign w_acc_total = r_acc + ACC_W'(r_sample);
  assign w_avg_shift = w_acc_total >> AVG_LOG2;

  // Completion in the last allowed cycle wins over the timeout.
  assign w_to_set  = (r_state == S_WAIT) && !w_cs_rise && (r_to_cnt == TO_LAST);
  // A trigger arriving while busy is dropped, not queued.
  assign w_ovr_set = (w_tick && (r_state != S_IDLE)) ||
                     (w_load && o_avg_valid && !i_avg_ready);

  // Free-running sample trigger; held at 0 while sampling is disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
    end else if (!i_enable || (r_tick_cnt == TICK_LAST)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs_n_q <= 1'b1;
    end else begin
      r_cs_n_q <= i_spi_cs_n;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      o_spi_start   <= 1'b0;
      r_to_cnt      <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_sample      <= '0;
      o_avg_data    <= '0;
      o_avg_valid   <= 1'b0;
      o_err_timeout <= 1'b0;
      o_err_overrun <= 1'b0;
    end else begin
      o_spi_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state     <= S_START;
            o_spi_start <= 1'b1;
          end
        end
        S_START: begin
          // The start cycle counts as the first elapsed cycle. The abort edge
          // is therefore the TIMEOUT_CYC-th edge after the pulse, and the
          // error becomes visible exactly TIMEOUT_CYC cycles after it.
          r_to_cnt <= TO_W'(1);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (w_cs_rise) begin
            r_sample <= i_spi_data;
            r_state  <= S_ACCUM;
          end else if (w_to_set) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_win_done) begin
            r_acc <= '0;
            r_cnt <= '0;
          end else begin
            r_acc <= w_acc_total;
            r_cnt <= r_cnt + 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        o_avg_data  <= w_avg_shift[15:0];
        o_avg_valid <= 1'b1;
      end else if (o_avg_valid && i_avg_ready) begin
        o_avg_valid <= 1'b0;
      end

      o_err_timeout <= (o_err_timeout && !i_err_clr) || w_to_set;
      o_err_overrun <= (o_err_overrun && !i_err_clr) || w_ovr_set;
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  logic [15:0] r_min_run;
  logic [15:0] r_max_run;
  logic [15:0] w_min_next;
  logic [15:0] w_max_next;

  // The first sample of a window (count 0) restarts the running extremes.
  assign w_min_next = ((r_cnt == '0) || (r_sample < r_min_run)) ? r_sample : r_min_run;
  assign w_max_next = ((r_cnt == '0) || (r_sample > r_max_run)) ? r_sample : r_max_run;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_min_run <= '0;
      r_max_run <= '0;
      o_avg_min <= '0;
      o_avg_max <= '0;
    end else if (r_state == S_ACCUM) begin
      r_min_run <= w_min_next;
      r_max_run <= w_max_next;
      if (w_win_done) begin
        o_avg_min <= w_min_next;
        o_avg_max <= w_max_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
module tb_adc_sample_averager;

  localparam int SAMPLE_DIV  = 100;
  localparam int AVG_LOG2    = 2;
  localparam int TIMEOUT_CYC = 64;
  localparam int WIN         = 1 << AVG_LOG2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic [15:0] spi_data = '0;
  logic        avg_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic        o_spi_start;
  logic [15:0] o_avg_data;
  logic        o_avg_valid;
  logic        o_err_timeout;
  logic        o_err_overrun;
  logic [1:0]  o_dbg_state;
`ifdef ADC_AVG_MINMAX_EN
  logic [15:0] o_avg_min;
  logic [15:0] o_avg_max;
`endif

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  adc_sample_averager #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .AVG_LOG2   (AVG_LOG2),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .o_spi_start  (o_spi_start),
    .i_spi_cs_n   (spi_cs_n),
    .i_spi_data   (spi_data),
    .o_avg_data   (o_avg_data),
    .o_avg_valid  (o_avg_valid),
    .i_avg_ready  (avg_ready),
    .o_err_timeout(o_err_timeout),
    .o_err_overrun(o_err_overrun),
    .i_err_clr    (err_clr),
`ifdef ADC_AVG_MINMAX_EN
    .o_avg_min    (o_avg_min),
    .o_avg_max    (o_avg_max),
`endif
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  logic [15:0] exp_q[$];
`ifdef ADC_AVG_MINMAX_EN
  logic [15:0] exp_min_q[$];
  logic [15:0] exp_max_q[$];
`endif
  int          win_q[$];      // samples of the window in progress
  logic [15:0] adc_q[$];      // words the ADC model returns next
  logic [15:0] last_avg;
  logic [15:0] last_min;
  logic [15:0] last_max;
  int          n_model_avgs = 0;

  // Reference: average = floor(sum of WIN samples / WIN).
  task automatic model_sample(input logic [15:0] w, output bit done);
    int sum;
    int mn;
    int mx;
    win_q.push_back(int'(w));
    done = 1'b0;
    if (win_q.size() == WIN) begin
      sum = 0;
      mn  = 65535;
      mx  = 0;
      foreach (win_q[i]) begin
        sum += win_q[i];
        if (win_q[i] < mn) mn = win_q[i];
        if (win_q[i] > mx) mx = win_q[i];
      end
      last_avg = 16'(sum / WIN);
      last_min = 16'(mn);
      last_max = 16'(mx);
      exp_q.push_back(last_avg);
`ifdef ADC_AVG_MINMAX_EN
      exp_min_q.push_back(last_min);
      exp_max_q.push_back(last_max);
`endif
      win_q.delete();
      n_model_avgs++;
      done = 1'b1;
    end
  endtask

  // ---------------- ADC model (driver) ----------------
  bit stall = 1'b0;

  initial begin
    int d;
    logic [15:0] w;
    bit done;
    forever begin
      @(negedge clk);
      if (!rst && o_spi_start && !stall) begin
        @(posedge clk); #1 spi_cs_n = 1'b0;
        d = $urandom_range(3, 30);
        repeat (d) @(posedge clk);
        #1;
        w = (adc_q.size() != 0) ? adc_q.pop_front() : 16'($urandom_range(0, 65535));
        spi_data = w;
        spi_cs_n = 1'b1;
        model_sample(w, done);
        if (done) begin
          // The average must be presented two cycles after the completion cycle.
          repeat (3) @(negedge clk);
          check_val("lat_valid", 32'(o_avg_valid), 32'd1);
          check_val("lat_data", 32'(o_avg_data), 32'(last_avg));
`ifdef ADC_AVG_MINMAX_EN
          check_val("lat_min", 32'(o_avg_min), 32'(last_min));
          check_val("lat_max", 32'(o_avg_max), 32'(last_max));
`endif
        end
        @(posedge clk); #1 spi_data = 16'($urandom_range(0, 65535));
      end
    end
  end

  // ---------------- ready driver ----------------
  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) avg_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor ----------------
  bit          mon_en = 1'b1;
  int          n_starts = 0;
  int          start_cyc = 0;
  int          err_cyc = 0;
  bit          err_to_prev = 1'b0;
  int          acc_cnt = 0;
  logic [15:0] last_acc = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_spi_start) begin
        n_starts++;
        start_cyc = cyc;
      end
      if (o_err_timeout && !err_to_prev) err_cyc = cyc;
      err_to_prev = o_err_timeout;
      if (mon_en && o_avg_valid && avg_ready) begin
        if (exp_q.size() == 0) begin
          check_val("avg_expected", 32'd0, 32'd1);
        end else begin
          check_val("avg_data", 32'(o_avg_data), 32'(exp_q.pop_front()));
`ifdef ADC_AVG_MINMAX_EN
          check_val("avg_min", 32'(o_avg_min), 32'(exp_min_q.pop_front()));
          check_val("avg_max", 32'(o_avg_max), 32'(exp_max_q.pop_front()));
`endif
        end
        acc_cnt++;
        last_acc = o_avg_data;
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic wait_avgs(input int target, input int budget);
    int k;
    k = 0;
    while (acc_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (acc_cnt < target) check_val("wait_avg_timeout", 32'(acc_cnt), 32'(target));
  endtask

  task automatic wait_win(input int n, input int budget);
    int k;
    k = 0;
    while (win_q.size() != n && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    if (win_q.size() != n) check_val("wait_win_timeout", 32'(win_q.size()), 32'(n));
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int k;
    int en_cyc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_start", 32'(o_spi_start), 32'd0);
    check_val("rst_valid", 32'(o_avg_valid), 32'd0);
    check_val("rst_data", 32'(o_avg_data), 32'd0);
    check_val("rst_err_to", 32'(o_err_timeout), 32'd0);
    check_val("rst_err_ov", 32'(o_err_overrun), 32'd0);
    check_val("rst_state", 32'(o_dbg_state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic average: 100,200,300,400 -> 250
    avg_ready = 1'b1;
    adc_q = '{16'd100, 16'd200, 16'd300, 16'd400};
    @(posedge clk); #1 enable = 1'b1;
    wait_avgs(acc_cnt + 1, 1500);
    check_val("avg_250", 32'(last_acc), 32'd250);
    check_val("no_ovr_a", 32'(o_err_overrun), 32'd0);

    // Full-scale samples must not overflow
    adc_q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    wait_avgs(acc_cnt + 1, 1500);
    check_val("avg_ffff", 32'(last_acc), 32'hFFFF);

`ifdef ADC_AVG_MINMAX_EN
    adc_q = '{16'd5, 16'd900, 16'd17, 16'd42};
    wait_avgs(acc_cnt + 1, 1500);
    check_val("avg_241", 32'(last_acc), 32'd241);
    check_val("min_5", 32'(o_avg_min), 32'd5);
    check_val("max_900", 32'(o_avg_max), 32'd900);
`endif

    // Back-pressure across two averages: second overwrites the first
    mon_en = 1'b0;
    @(posedge clk); #1 avg_ready = 1'b0;
    adc_q = '{16'd10, 16'd10, 16'd10, 16'd10, 16'd20, 16'd20, 16'd20, 16'd20};
    s0 = n_model_avgs + 2;
    k = 0;
    while (n_model_avgs < s0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check_val("ovr_model_avgs", 32'(n_model_avgs), 32'(s0));
    repeat (4) @(negedge clk);
    check_val("ovr_data", 32'(o_avg_data), 32'd20);
    check_val("ovr_valid", 32'(o_avg_valid), 32'd1);
    check_val("ovr_flag", 32'(o_err_overrun), 32'd1);
    pulse_clr();
    check_val("ovr_clr", 32'(o_err_overrun), 32'd0);
    check_val("ovr_clr_valid", 32'(o_avg_valid), 32'd1);
    @(posedge clk); #1 avg_ready = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.delete();
`ifdef ADC_AVG_MINMAX_EN
    exp_min_q.delete();
    exp_max_q.delete();
`endif
    mon_en = 1'b1;

    // Disable mid-window: partial sum kept, no starts while disabled
    wait_win(2, 2000);
    enable = 1'b0;
    s0 = n_starts;
    repeat (1000) @(posedge clk);
    check_val("dis_no_start", 32'(n_starts), 32'(s0));
    check_val("dis_state", 32'(o_dbg_state), 32'd0);
    #1 enable = 1'b1;
    en_cyc = cyc;
    k = 0;
    while (n_starts == s0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check_val("en_first_start", 32'(start_cyc - en_cyc), 32'(SAMPLE_DIV));
    wait_avgs(acc_cnt + 1, 1500);

    // Timeout with a partial window: partial discarded, clean restart
    wait_win(2, 2000);
    stall = 1'b1;
    s0 = n_starts;
    k = 0;
    while (n_starts == s0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    check_val("to_got_start", 32'(n_starts), 32'(s0 + 1));
    k = 0;
    while (!o_err_timeout && k < 200) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check_val("to_flag", 32'(o_err_timeout), 32'd1);
    check_val("to_latency", 32'(err_cyc - start_cyc), 32'(TIMEOUT_CYC));
    check_val("to_state_idle", 32'(o_dbg_state), 32'd0);
    check_val("to_no_ovr", 32'(o_err_overrun), 32'd0);
    win_q.delete();
    stall = 1'b0;
    pulse_clr();
    check_val("to_clr", 32'(o_err_timeout), 32'd0);
    wait_avgs(acc_cnt + 1, 1500);

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    wait_avgs(acc_cnt + 15, 8000);
    rand_ready = 1'b0;
    @(posedge clk); #1 avg_ready = 1'b1;
    repeat (10) @(posedge clk);
    check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check_val("end_no_ovr", 32'(o_err_overrun), 32'd0);
    check_val("end_no_to", 32'(o_err_timeout), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
